// File: rtl/riscv_mul_arbiter_pkg.sv
// Shared constants and types for the dual-core multiplier arbiter:
// core count, the in-flight tag layout and the request bundle.
package riscv_mul_arbiter_pkg;

  localparam int MUL_ARB_CORES = 2;
  localparam int TAG_RD_W      = 5;

  typedef struct packed {
    logic                live;
    logic                core;
    logic [TAG_RD_W-1:0] rd_idx;
  } mul_tag_t;

  localparam int TAG_W = $bits(mul_tag_t);

  typedef struct packed {
    logic [31:0]         opcode;
    logic [31:0]         pc;
    logic [31:0]         ra;
    logic [31:0]         rb;
    logic [TAG_RD_W-1:0] rd_idx;
  } mul_req_t;

endpackage

// File: rtl/riscv_mul_arbiter_if.sv
// Core request/response ports and multiplier drive bus of the arbiter.
// slave = arbiter side, master = cores plus multiplier side.
interface riscv_mul_arbiter_if;

  logic        req0_valid_i, req1_valid_i;
  logic [31:0] req0_opcode_i, req1_opcode_i;
  logic [31:0] req0_pc_i, req1_pc_i;
  logic [4:0]  req0_rd_idx_i, req1_rd_idx_i;
  logic [31:0] req0_ra_operand_i, req1_ra_operand_i;
  logic [31:0] req0_rb_operand_i, req1_rb_operand_i;
  logic        req0_ready_o, req1_ready_o;
  logic        flush0_i, flush1_i;
  logic        resp0_valid_o, resp1_valid_o;
  logic [31:0] resp0_value_o, resp1_value_o;
  logic [4:0]  resp0_rd_idx_o, resp1_rd_idx_o;
  logic        resp0_accept_i, resp1_accept_i;
  logic        mul_valid_o;
  logic [31:0] mul_opcode_o, mul_pc_o, mul_ra_operand_o, mul_rb_operand_o;
  logic [4:0]  mul_rd_idx_o;
  logic [31:0] mul_result_i;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_opcode_i, req1_opcode_i,
           req0_pc_i, req1_pc_i, req0_rd_idx_i, req1_rd_idx_i,
           req0_ra_operand_i, req1_ra_operand_i, req0_rb_operand_i, req1_rb_operand_i,
           flush0_i, flush1_i, resp0_accept_i, resp1_accept_i, mul_result_i,
    output req0_ready_o, req1_ready_o,
           resp0_valid_o, resp1_valid_o, resp0_value_o, resp1_value_o,
           resp0_rd_idx_o, resp1_rd_idx_o,
           mul_valid_o, mul_opcode_o, mul_pc_o, mul_ra_operand_o, mul_rb_operand_o,
           mul_rd_idx_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_opcode_i, req1_opcode_i,
           req0_pc_i, req1_pc_i, req0_rd_idx_i, req1_rd_idx_i,
           req0_ra_operand_i, req1_ra_operand_i, req0_rb_operand_i, req1_rb_operand_i,
           flush0_i, flush1_i, resp0_accept_i, resp1_accept_i, mul_result_i,
    input  req0_ready_o, req1_ready_o,
           resp0_valid_o, resp1_valid_o, resp0_value_o, resp1_value_o,
           resp0_rd_idx_o, resp1_rd_idx_o,
           mul_valid_o, mul_opcode_o, mul_pc_o, mul_ra_operand_o, mul_rb_operand_o,
           mul_rd_idx_o
  );

endinterface

// File: rtl/riscv_mul_arb_tag_pipe.sv
// Tag shift register that tracks multiplier operations in flight, one entry
// per multiplier stage, with a per-core kill that clears live bits.
module riscv_mul_arb_tag_pipe
  import riscv_mul_arbiter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  mul_tag_t                 load,
  input  logic [MUL_ARB_CORES-1:0] kill,
  output mul_tag_t                 tail,
  output logic [MUL_ARB_CORES-1:0] live
);

  mul_tag_t stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= load;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i]      <= stage_q[i-1];
        stage_q[i].live <= stage_q[i-1].live & ~kill[stage_q[i-1].core];
      end
    end
  end

  assign tail = stage_q[STAGES-1];

  // Per-core "anything live in flight" summary feeds the busy logic.
  always_comb begin
    live = '0;
    for (int i = 0; i < STAGES; i++)
      if (stage_q[i].live) live[stage_q[i].core] = 1'b1;
  end

endmodule

// File: rtl/riscv_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier between two cores, with
// tag tracking, per-core response buffers and flush of outstanding work.
module riscv_mul_arbiter
  import riscv_mul_arbiter_pkg::*;
#(
  parameter int MULT_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  riscv_mul_arbiter_if.slave bus
);

  localparam int NC = MUL_ARB_CORES;

  logic [NC-1:0] req_valid, flush, accept;
  logic [NC-1:0] inflight, busy, free, eligible, grant, wr;
  mul_req_t      req [NC];
  mul_req_t      sel;
  mul_tag_t      load, tail;
  logic          last_q, gsel;

  logic [NC-1:0]                resp_valid_q;
  logic [NC-1:0][31:0]          resp_value_q;
  logic [NC-1:0][TAG_RD_W-1:0]  resp_rd_q;

  assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
  assign flush     = {bus.flush1_i, bus.flush0_i};
  assign accept    = {bus.resp1_accept_i, bus.resp0_accept_i};

  assign req[0] = '{opcode: bus.req0_opcode_i, pc: bus.req0_pc_i, ra: bus.req0_ra_operand_i,
                    rb: bus.req0_rb_operand_i, rd_idx: bus.req0_rd_idx_i};
  assign req[1] = '{opcode: bus.req1_opcode_i, pc: bus.req1_pc_i, ra: bus.req1_ra_operand_i,
                    rb: bus.req1_rb_operand_i, rd_idx: bus.req1_rd_idx_i};

  // A buffered result being accepted this cycle frees the core immediately.
  always_comb begin
    busy     = inflight | resp_valid_q;
    free     = ~busy | (resp_valid_q & accept & ~inflight);
    eligible = req_valid & free & ~flush & {NC{~rst_i}};
    grant    = eligible;
    if (&eligible) begin
      grant          = '0;
      grant[~last_q] = 1'b1;
    end
  end

  assign gsel = grant[1];
  assign sel  = (|grant) ? req[gsel] : '0;

  assign bus.req0_ready_o     = grant[0];
  assign bus.req1_ready_o     = grant[1];
  assign bus.mul_valid_o      = |grant;
  assign bus.mul_opcode_o     = sel.opcode;
  assign bus.mul_pc_o         = sel.pc;
  assign bus.mul_ra_operand_o = sel.ra;
  assign bus.mul_rb_operand_o = sel.rb;
  assign bus.mul_rd_idx_o     = sel.rd_idx;

  assign load = '{live: |grant, core: gsel, rd_idx: sel.rd_idx};

  riscv_mul_arb_tag_pipe #(
    .STAGES (MULT_STAGES)
  ) u_tag_pipe (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (load),
    .kill (flush),
    .tail (tail),
    .live (inflight)
  );

  // A flush landing on the same cycle as the result suppresses the write.
  always_comb begin
    wr = '0;
    for (int n = 0; n < NC; n++)
      wr[n] = tail.live & (tail.core == n[0]) & ~flush[n];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= 1'b1;
      resp_valid_q <= '0;
      resp_value_q <= '0;
      resp_rd_q    <= '0;
    end else begin
      if (|grant) last_q <= gsel;
      for (int n = 0; n < NC; n++) begin
        if (flush[n]) begin
          resp_valid_q[n] <= 1'b0;
        end else if (wr[n]) begin
          resp_valid_q[n] <= 1'b1;
          resp_value_q[n] <= bus.mul_result_i;
          resp_rd_q[n]    <= tail.rd_idx;
        end else if (accept[n]) begin
          resp_valid_q[n] <= 1'b0;
        end
      end
    end
  end

  assign bus.resp0_valid_o  = resp_valid_q[0];
  assign bus.resp1_valid_o  = resp_valid_q[1];
  assign bus.resp0_value_o  = resp_value_q[0];
  assign bus.resp1_value_o  = resp_value_q[1];
  assign bus.resp0_rd_idx_o = resp_rd_q[0];
  assign bus.resp1_rd_idx_o = resp_rd_q[1];

endmodule

// File: tb/tb_riscv_mul_arbiter.sv
// Directed bench for riscv_mul_arbiter with a behavioural multiplier of
// matching latency; set MS to 2 or 3 to exercise both pipeline depths.
module tb_riscv_mul_arbiter;

  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_mul_arbiter_if bus ();

  riscv_mul_arbiter #(.MULT_STAGES(MS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] mul_model(input logic [31:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] xa, xb, p;
    if (op[6:0] != 7'h33 || op[31:25] != 7'h01 || op[14]) return '0;
    xa = (op[13:12] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    xb = op[13] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = xa * xb;
    return (op[13:12] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier stand-in: result appears MS cycles after the sampling edge.
  logic [31:0] mpipe [MS];
  assign bus.mul_result_i = mpipe[MS-1];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MS; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= bus.mul_valid_o ?
                  mul_model(bus.mul_opcode_o, bus.mul_ra_operand_o, bus.mul_rb_operand_o) : '0;
      for (int i = 1; i < MS; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  task automatic set0(input logic v, input logic [31:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    bus.req0_valid_i = v; bus.req0_opcode_i = op; bus.req0_pc_i = 32'h1000;
    bus.req0_ra_operand_i = a; bus.req0_rb_operand_i = b; bus.req0_rd_idx_i = rd;
  endtask

  task automatic set1(input logic v, input logic [31:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    bus.req1_valid_i = v; bus.req1_opcode_i = op; bus.req1_pc_i = 32'h2000;
    bus.req1_ra_operand_i = a; bus.req1_rb_operand_i = b; bus.req1_rd_idx_i = rd;
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    set0(1'b0, '0, '0, '0, '0);
    set1(1'b0, '0, '0, '0, '0);
    bus.flush0_i = 1'b0; bus.flush1_i = 1'b0;
    bus.resp0_accept_i = 1'b1; bus.resp1_accept_i = 1'b1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic drain;
    idle_inputs();
    repeat (MS + 3) nxt();
  endtask

  // A response buffer must never be written in the cycle its result is consumed.
  always @(negedge clk)
    if (!rst)
      chk("wr_vs_accept", 32'(|(dut.wr & {bus.resp1_valid_o & bus.resp1_accept_i,
                                          bus.resp0_valid_o & bus.resp0_accept_i})), 0);

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #2;
    chk("rst_resp0_v", 32'(bus.resp0_valid_o), 0);
    chk("rst_resp1_v", 32'(bus.resp1_valid_o), 0);
    chk("rst_resp0_val", bus.resp0_value_o, 0);
    chk("rst_mul_v", 32'(bus.mul_valid_o), 0);
    chk("rst_mul_op", bus.mul_opcode_o, 0);
    nxt();
    rst = 1'b0;

    // Single MUL on core 0
    set0(1'b1, enc(3'b000, 5'd5), 32'd7, 32'd6, 5'd5);
    smp();
    chk("s1_rdy0", 32'(bus.req0_ready_o), 1);
    chk("s1_rdy1", 32'(bus.req1_ready_o), 0);
    chk("s1_mul_v", 32'(bus.mul_valid_o), 1);
    chk("s1_mul_ra", bus.mul_ra_operand_o, 7);
    chk("s1_mul_rd", 32'(bus.mul_rd_idx_o), 5);
    nxt();
    set0(1'b0, '0, '0, '0, '0);
    for (int c = 1; c <= MS; c++) begin
      smp();
      chk("s1_early_v", 32'(bus.resp0_valid_o), 0);
      chk("s1_idle_mul_op", bus.mul_opcode_o, 0);
      nxt();
    end
    smp();
    chk("s1_resp0_v", 32'(bus.resp0_valid_o), 1);
    chk("s1_resp0_val", bus.resp0_value_o, 42);
    chk("s1_resp0_rd", 32'(bus.resp0_rd_idx_o), 5);
    chk("s1_resp1_v", 32'(bus.resp1_valid_o), 0);
    nxt();
    smp();
    chk("s1_consumed", 32'(bus.resp0_valid_o), 0);
    drain();

    // Both cores request every cycle from reset
    do_reset();
    set0(1'b1, enc(3'b011, 5'd1), 32'hFFFF_FFFF, 32'd2, 5'd1);
    set1(1'b1, enc(3'b001, 5'd2), 32'h8000_0000, 32'd2, 5'd2);
    for (int c = 0; c < 3 * (MS + 1); c++) begin
      smp();
      chk("s2_rdy0", 32'(bus.req0_ready_o), 32'(c % (MS + 1) == 0));
      chk("s2_rdy1", 32'(bus.req1_ready_o), 32'(c % (MS + 1) == 1));
      if (c > 0 && c % (MS + 1) == 0) begin
        chk("s2_resp0_v", 32'(bus.resp0_valid_o), 1);
        chk("s2_resp0_val", bus.resp0_value_o, 1);
      end
      if (c > 1 && c % (MS + 1) == 1) begin
        chk("s2_resp1_v", 32'(bus.resp1_valid_o), 1);
        chk("s2_resp1_val", bus.resp1_value_o, 32'hFFFF_FFFF);
      end
      nxt();
    end
    drain();

    // Core 0 withholds accept; core 1 keeps flowing
    do_reset();
    bus.resp0_accept_i = 1'b0;
    set0(1'b1, enc(3'b011, 5'd1), 32'hFFFF_FFFF, 32'd2, 5'd1);
    set1(1'b1, enc(3'b001, 5'd2), 32'h8000_0000, 32'd2, 5'd2);
    for (int c = 0; c < 15; c++) begin
      smp();
      chk("s3_rdy0", 32'(bus.req0_ready_o), 32'(c == 0));
      chk("s3_rdy1", 32'(bus.req1_ready_o), 32'(c >= 1 && (c - 1) % (MS + 1) == 0));
      if (c > MS) chk("s3_resp0_hold", 32'(bus.resp0_valid_o), 1);
      nxt();
    end
    bus.resp0_accept_i = 1'b1;
    smp();
    chk("s3_regrant0", 32'(bus.req0_ready_o), 1);
    chk("s3_resp0_val", bus.resp0_value_o, 1);
    nxt();
    drain();

    // Flush one cycle after a core 0 grant, then a fresh request
    do_reset();
    set0(1'b1, enc(3'b000, 5'd7), 32'd3, 32'd5, 5'd7);
    smp();
    chk("s4_rdy0_a", 32'(bus.req0_ready_o), 1);
    nxt();
    set0(1'b0, '0, '0, '0, '0);
    bus.flush0_i = 1'b1;
    nxt();
    bus.flush0_i = 1'b0;
    set0(1'b1, enc(3'b000, 5'd8), 32'd9, 32'd9, 5'd8);
    smp();
    chk("s4_rdy0_b", 32'(bus.req0_ready_o), 1);
    nxt();
    set0(1'b0, '0, '0, '0, '0);
    for (int c = 3; c <= MS + 2; c++) begin
      smp();
      chk("s4_no_resp", 32'(bus.resp0_valid_o), 0);
      nxt();
    end
    smp();
    chk("s4_resp0_v", 32'(bus.resp0_valid_o), 1);
    chk("s4_resp0_val", bus.resp0_value_o, 81);
    chk("s4_resp0_rd", 32'(bus.resp0_rd_idx_o), 8);
    nxt();
    drain();

    // Reset with two operations in flight
    do_reset();
    set1(1'b1, enc(3'b000, 5'd3), 32'd2, 32'd3, 5'd3);
    smp();
    chk("s5_rdy1", 32'(bus.req1_ready_o), 1);
    nxt();
    set1(1'b0, '0, '0, '0, '0);
    set0(1'b1, enc(3'b000, 5'd4), 32'd4, 32'd4, 5'd4);
    smp();
    chk("s5_rdy0", 32'(bus.req0_ready_o), 1);
    nxt();
    set1(1'b1, enc(3'b000, 5'd3), 32'd2, 32'd3, 5'd3);
    rst = 1'b1;
    #1;
    chk("s5_rst_rdy0", 32'(bus.req0_ready_o), 0);
    chk("s5_rst_rdy1", 32'(bus.req1_ready_o), 0);
    chk("s5_rst_mul_v", 32'(bus.mul_valid_o), 0);
    chk("s5_rst_mul_op", bus.mul_opcode_o, 0);
    chk("s5_rst_resp0", 32'(bus.resp0_valid_o), 0);
    chk("s5_rst_resp1", 32'(bus.resp1_valid_o), 0);
    idle_inputs();
    nxt();
    rst = 1'b0;
    for (int c = 0; c < MS + 3; c++) begin
      smp();
      chk("s5_lost_resp0", 32'(bus.resp0_valid_o), 0);
      chk("s5_lost_resp1", 32'(bus.resp1_valid_o), 0);
      nxt();
    end
    set0(1'b1, enc(3'b000, 5'd4), 32'd4, 32'd4, 5'd4);
    set1(1'b1, enc(3'b000, 5'd3), 32'd2, 32'd3, 5'd3);
    smp();
    chk("s5_tie_rdy0", 32'(bus.req0_ready_o), 1);
    chk("s5_tie_rdy1", 32'(bus.req1_ready_o), 0);
    nxt();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
